lb_switch_ctl: RTL and testbench

//  Loopback switch controller for the transmit pin. It takes a debounced

---
 rtl/lb_switch_ctl.sv | 159 +++++++++++++++
 tb/tb_lb_switch_ctl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lb_switch_ctl.sv
// Loopback switch controller for the transmit pin.
// Moves txd_o between the normal UART path and the raw rxd loopback path,
// but only after the transmitter has drained and rxd has been idle (mark)
// for IDLE_CYCLES consecutive synchronized samples. While changing over,
// txd_o is parked at mark so the far end never sees a partial character.
module lb_switch_ctl #(
  parameter logic [15:0] IDLE_CYCLES = 16'd8680
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx_n,
  input  logic       lb_req_i,
  input  logic       tx_busy_i,
  input  logic       txd_tx,
  input  logic       rxd_i,
  output logic       tx_pause_o,
  output logic       lb_active_o,
  output logic [2:0] state_o,
  output logic       txd_o
);

  localparam int unsigned CNT_W = $clog2(32'(IDLE_CYCLES) + 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_QUIET = CNT_W'(IDLE_CYCLES - 16'd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    NORM      = 3'd0,
    DRAIN     = 3'd1,
    QUIET_IN  = 3'd2,
    LOOP      = 3'd3,
    QUIET_OUT = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic             rxd_meta_r;
  logic             rxd_s;
  logic             quiet_s;
  logic             enter_quiet_s;
  logic             pause_nx_s;
  logic             active_nx_s;
  logic             mark_nx_s;
  logic             pause_r;
  logic             active_r;
  logic             mark_r;

  // rxd is only ever judged idle after it has been synchronized and held
  // high for the full window; the last count before saturation marks quiet.
  assign quiet_s = (cnt_r == CNT_QUIET) && rxd_s;

  // Next-state selection; a dropped request always wins over progress.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      NORM: begin
        if (lb_req_i) state_nx_s = DRAIN;
        else          state_nx_s = NORM;
      end
      DRAIN: begin
        if (!lb_req_i)      state_nx_s = NORM;
        else if (!tx_busy_i) state_nx_s = QUIET_IN;
        else                state_nx_s = DRAIN;
      end
      QUIET_IN: begin
        if (!lb_req_i)   state_nx_s = NORM;
        else if (quiet_s) state_nx_s = LOOP;
        else             state_nx_s = QUIET_IN;
      end
      LOOP: begin
        if (!lb_req_i) state_nx_s = QUIET_OUT;
        else           state_nx_s = LOOP;
      end
      QUIET_OUT: begin
        if (lb_req_i)    state_nx_s = LOOP;
        else if (quiet_s) state_nx_s = NORM;
        else             state_nx_s = QUIET_OUT;
      end
      default: state_nx_s = NORM;
    endcase
  end

  // Output decode of the upcoming state so the outputs come straight from flops.
  always_comb begin
    pause_nx_s    = 1'b1;
    active_nx_s   = 1'b0;
    mark_nx_s     = 1'b0;
    enter_quiet_s = 1'b0;
    case (state_nx_s)
      NORM:      pause_nx_s  = 1'b0;
      DRAIN:     mark_nx_s   = 1'b0;
      QUIET_IN:  mark_nx_s   = 1'b1;
      LOOP:      active_nx_s = 1'b1;
      QUIET_OUT: mark_nx_s   = 1'b1;
      default:   pause_nx_s  = 1'b0;
    endcase
    if ((state_nx_s != state_r) &&
        ((state_nx_s == QUIET_IN) || (state_nx_s == QUIET_OUT))) begin
      enter_quiet_s = 1'b1;
    end else begin
      enter_quiet_s = 1'b0;
    end
  end

  // Two-flop synchronizer for the asynchronous rxd pin (idle detection only).
  always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
    if (!rst_clk_tx_n) begin
      rxd_meta_r <= 1'b1;
      rxd_s      <= 1'b1;
    end else begin
      rxd_meta_r <= rxd_i;
      rxd_s      <= rxd_meta_r;
    end
  end

  // Idle counter: restarts on quiet-state entry or any low sample, saturates.
  always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
    if (!rst_clk_tx_n) begin
      cnt_r <= '0;
    end else if (enter_quiet_s || !rxd_s) begin
      cnt_r <= '0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // State register together with its registered output controls.
  always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
    if (!rst_clk_tx_n) begin
      state_r  <= NORM;
      pause_r  <= 1'b0;
      active_r <= 1'b0;
      mark_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      pause_r  <= pause_nx_s;
      active_r <= active_nx_s;
      mark_r   <= mark_nx_s;
    end
  end

  // Pin mux: raw rxd in loopback so echoed data sees no added latency.
  always_comb begin
    if (active_r) begin
      txd_o = rxd_i;
    end else if (mark_r) begin
      txd_o = 1'b1;
    end else begin
      txd_o = txd_tx;
    end
  end

  assign tx_pause_o  = pause_r;
  assign lb_active_o = active_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_lb_switch_ctl.sv
// Directed bench for lb_switch_ctl with a 16-cycle idle window.
module tb_lb_switch_ctl;

  logic       clk_tx;
  logic       clk_en;
  logic       rst_clk_tx_n;
  logic       lb_req_i;
  logic       tx_busy_i;
  logic       txd_tx;
  logic       rxd_i;
  logic       tx_pause_o;
  logic       lb_active_o;
  logic [2:0] state_o;
  logic       txd_o;

  int total;
  int bad;

  lb_switch_ctl #(.IDLE_CYCLES(16'd16)) dut (
    .clk_tx       (clk_tx),
    .rst_clk_tx_n (rst_clk_tx_n),
    .lb_req_i     (lb_req_i),
    .tx_busy_i    (tx_busy_i),
    .txd_tx       (txd_tx),
    .rxd_i        (rxd_i),
    .tx_pause_o   (tx_pause_o),
    .lb_active_o  (lb_active_o),
    .state_o      (state_o),
    .txd_o        (txd_o)
  );

  // Gated clock so reset behaviour can be checked with no edges at all.
  initial clk_tx = 1'b0;
  always begin
    #5;
    if (clk_en) clk_tx = ~clk_tx;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_tx);
    #1;
  endtask

  // Watchdog: the sequence is a few hundred cycles long.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    total = 0; bad = 0;
    clk_en = 1'b0; rst_clk_tx_n = 1'b0;
    lb_req_i = 1'b0; tx_busy_i = 1'b0; txd_tx = 1'b0; rxd_i = 1'b1;
    #3;
    // 1. reset with no clock
    chk("rst_state", {1'b0, state_o}, 4'd0);
    chk("rst_pause", {3'd0, tx_pause_o}, 4'd0);
    chk("rst_active", {3'd0, lb_active_o}, 4'd0);
    chk("rst_txd0", {3'd0, txd_o}, 4'd0);
    txd_tx = 1'b1; #1;
    chk("rst_txd1", {3'd0, txd_o}, 4'd1);
    txd_tx = 1'b0; #1;
    chk("rst_txd2", {3'd0, txd_o}, 4'd0);
    rst_clk_tx_n = 1'b1; #2;
    clk_en = 1'b1;
    step(3);
    chk("norm_state", {1'b0, state_o}, 4'd0);

    // 2. entry with tx idle and rxd long high
    lb_req_i = 1'b1;
    step(1);
    chk("drain_state", {1'b0, state_o}, 4'd1);
    chk("drain_pause", {3'd0, tx_pause_o}, 4'd1);
    chk("drain_txd", {3'd0, txd_o}, 4'd0);
    step(1);
    chk("qin_state", {1'b0, state_o}, 4'd2);
    chk("qin_mark", {3'd0, txd_o}, 4'd1);
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("qin_hold", {1'b0, state_o}, 4'd2);
    end
    chk("qin_mark_end", {3'd0, txd_o}, 4'd1);
    step(1);
    chk("loop_state", {1'b0, state_o}, 4'd3);
    chk("loop_active", {3'd0, lb_active_o}, 4'd1);
    rxd_i = 1'b0; #1;
    chk("loop_txd0", {3'd0, txd_o}, 4'd0);
    rxd_i = 1'b1; #1;
    chk("loop_txd1", {3'd0, txd_o}, 4'd1);

    // 5. leave loop, full quiet window back to NORM
    lb_req_i = 1'b0;
    step(1);
    chk("qout_state", {1'b0, state_o}, 4'd4);
    chk("qout_mark", {3'd0, txd_o}, 4'd1);
    chk("qout_pause", {3'd0, tx_pause_o}, 4'd1);
    step(15);
    chk("qout_hold", {1'b0, state_o}, 4'd4);
    step(1);
    chk("qout_norm", {1'b0, state_o}, 4'd0);
    chk("qout_unpause", {3'd0, tx_pause_o}, 4'd0);
    chk("qout_inactive", {3'd0, lb_active_o}, 4'd0);
    // back into loop, then abort the exit at count 5
    lb_req_i = 1'b1;
    step(18);
    chk("reloop_state", {1'b0, state_o}, 4'd3);
    lb_req_i = 1'b0;
    step(1);
    chk("qout2_state", {1'b0, state_o}, 4'd4);
    step(5);
    lb_req_i = 1'b1;
    step(1);
    chk("qout_abort", {1'b0, state_o}, 4'd3);

    // 4. rxd glitch at count 10 in QUIET_IN defers the switch
    lb_req_i = 1'b0;
    step(17);
    chk("g_norm", {1'b0, state_o}, 4'd0);
    lb_req_i = 1'b1;
    step(2);
    chk("g_qin", {1'b0, state_o}, 4'd2);
    step(10);
    rxd_i = 1'b0;
    step(1);
    rxd_i = 1'b1;
    step(5);
    chk("g_defer16", {1'b0, state_o}, 4'd2);
    step(12);
    chk("g_defer28", {1'b0, state_o}, 4'd2);
    step(1);
    chk("g_loop29", {1'b0, state_o}, 4'd3);

    // 3. request while the transmitter is busy
    lb_req_i = 1'b0;
    step(17);
    chk("b_norm", {1'b0, state_o}, 4'd0);
    tx_busy_i = 1'b1; lb_req_i = 1'b1;
    step(1);
    chk("b_drain", {1'b0, state_o}, 4'd1);
    for (int i = 0; i < 100; i++) begin
      txd_tx = i[0];
      step(1);
      chk("b_hold", {1'b0, state_o}, 4'd1);
      chk("b_txd", {3'd0, txd_o}, {3'd0, txd_tx});
    end
    chk("b_pause", {3'd0, tx_pause_o}, 4'd1);
    tx_busy_i = 1'b0; txd_tx = 1'b0;
    step(1);
    chk("b_qin", {1'b0, state_o}, 4'd2);
    tx_busy_i = 1'b1;
    step(16);
    chk("b_ignored", {1'b0, state_o}, 4'd3);
    tx_busy_i = 1'b0;

    // 6. asynchronous reset mid-LOOP
    txd_tx = 1'b0;
    #2 rst_clk_tx_n = 1'b0;
    #1;
    chk("ar_state", {1'b0, state_o}, 4'd0);
    chk("ar_active", {3'd0, lb_active_o}, 4'd0);
    chk("ar_pause", {3'd0, tx_pause_o}, 4'd0);
    chk("ar_txd", {3'd0, txd_o}, 4'd0);
    #2 rst_clk_tx_n = 1'b1;
    step(1);
    chk("ar_redrain", {1'b0, state_o}, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
